// File: rtl/hpc1_logic_vec.sv
// Masked W-bit, D-share two-input logic gadget (AND/NAND/NOR/OR) built on HPC1:
// refresh of b, one-cycle delay of a, DOM multiplication and share compression.
module hpc1_logic_vec #(
    parameter int SECURITY_ORDER = 2,
    parameter int W              = 8,
    parameter int OUT_REG        = 0
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        in_valid,
    input  logic [1:0]                                  mode,
    input  logic [W*(SECURITY_ORDER+1)-1:0]             ina,
    input  logic [W*(SECURITY_ORDER+1)-1:0]             inb,
    input  logic [W*(SECURITY_ORDER+1)*SECURITY_ORDER-1:0] rnd,
    output logic                                        out_valid,
    output logic [W*(SECURITY_ORDER+1)-1:0]             outt
);

    localparam int D  = SECURITY_ORDER + 1;
    localparam int P  = D * (D - 1) / 2;
    localparam int NR = W * P;
    localparam int WD = W * D;

    // Position of the unordered share pair (i,l), i<l, inside a bit's P-wide random slice.
    function automatic int pairIdx(input int i, input int l);
        return i * D - (i * (i + 1)) / 2 + (l - i - 1);
    endfunction

    logic [WD-1:0]      aDly_d, aDly_q;
    logic [WD-1:0]      bRef_d, bRef_q;
    logic               inv1_q, valid1_q;
    logic [W*D*D-1:0]   terms_d, terms_q;
    logic               inv2_q, valid2_q;
    logic [WD-1:0]      comp;

    // De Morgan input inversion touches share 0 only; b is then refreshed pairwise.
    always_comb begin
        aDly_d = ina;
        bRef_d = inb;
        if (mode[1]) begin
            aDly_d[W-1:0] = ~ina[W-1:0];
            bRef_d[W-1:0] = ~inb[W-1:0];
        end
        for (int j = 0; j < W; j++) begin
            for (int i = 0; i < D; i++) begin
                for (int l = i + 1; l < D; l++) begin
                    bRef_d[i*W+j] = bRef_d[i*W+j] ^ rnd[j*P+pairIdx(i, l)];
                    bRef_d[l*W+j] = bRef_d[l*W+j] ^ rnd[j*P+pairIdx(i, l)];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            aDly_q   <= '0;
            bRef_q   <= '0;
            inv1_q   <= 1'b0;
            valid1_q <= 1'b0;
        end else begin
            aDly_q   <= aDly_d;
            bRef_q   <= bRef_d;
            inv1_q   <= mode[0];
            valid1_q <= in_valid;
        end
    end

    // Term (i,l) of bit j; cross terms (i,l) and (l,i) share the same mask bit.
    always_comb begin
        terms_d = '0;
        for (int j = 0; j < W; j++) begin
            for (int i = 0; i < D; i++) begin
                for (int l = 0; l < D; l++) begin
                    terms_d[(j*D+i)*D+l] = aDly_q[i*W+j] & bRef_q[l*W+j];
                    if (i < l) begin
                        terms_d[(j*D+i)*D+l] = terms_d[(j*D+i)*D+l] ^ rnd[NR+j*P+pairIdx(i, l)];
                    end else if (i > l) begin
                        terms_d[(j*D+i)*D+l] = terms_d[(j*D+i)*D+l] ^ rnd[NR+j*P+pairIdx(l, i)];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            terms_q  <= '0;
            inv2_q   <= 1'b0;
            valid2_q <= 1'b0;
        end else begin
            terms_q  <= terms_d;
            inv2_q   <= inv1_q;
            valid2_q <= valid1_q;
        end
    end

    always_comb begin
        comp = '0;
        for (int j = 0; j < W; j++) begin
            for (int i = 0; i < D; i++) begin
                for (int l = 0; l < D; l++) begin
                    comp[i*W+j] = comp[i*W+j] ^ terms_q[(j*D+i)*D+l];
                end
            end
        end
        if (inv2_q) begin
            comp[W-1:0] = ~comp[W-1:0];
        end
    end

    generate
        if (OUT_REG != 0) begin : g_outReg
            logic [WD-1:0] outt_q;
            logic          outValid_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    outt_q     <= '0;
                    outValid_q <= 1'b0;
                end else begin
                    outt_q     <= comp;
                    outValid_q <= valid2_q;
                end
            end

            assign outt      = outt_q;
            assign out_valid = outValid_q;
        end else begin : g_noOutReg
            assign outt      = comp;
            assign out_valid = valid2_q;
        end
    endgenerate

endmodule

// File: tb/tb_hpc1_logic_vec.sv
// Scoreboard bench for hpc1_logic_vec: a first-order 4-bit instance (latency 2) and a
// second-order 8-bit instance with the output register (latency 3), checked against a plain logic model.
module tb_hpc1_logic_vec;

    typedef struct {
        logic [7:0] exp;
        int         due;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic        rstA_n, inValidA, outValidA;
    logic [1:0]  modeA;
    logic [7:0]  inaA, inbA, rndA, outtA;

    logic        rstB_n, inValidB, outValidB;
    logic [1:0]  modeB;
    logic [23:0] inaB, inbB, outtB;
    logic [47:0] rndB;

    logic monOnA = 1'b0;
    logic monOnB = 1'b0;
    exp_t qA[$];
    exp_t qB[$];

    hpc1_logic_vec #(.SECURITY_ORDER(1), .W(4), .OUT_REG(0)) dutA (
        .clk(clk), .rst_n(rstA_n), .in_valid(inValidA), .mode(modeA),
        .ina(inaA), .inb(inbA), .rnd(rndA), .out_valid(outValidA), .outt(outtA)
    );

    hpc1_logic_vec #(.SECURITY_ORDER(2), .W(8), .OUT_REG(1)) dutB (
        .clk(clk), .rst_n(rstB_n), .in_valid(inValidB), .mode(modeB),
        .ina(inaB), .inb(inbB), .rnd(rndB), .out_valid(outValidB), .outt(outtB)
    );

    // Random d-way XOR sharing of a w-bit value; share i of bit j sits at i*w+j.
    function automatic logic [23:0] maskSplit(input logic [7:0] v, input int w, input int d);
        logic [23:0] s;
        logic [7:0]  acc;
        logic [31:0] r;
        s   = '0;
        acc = v;
        for (int i = 1; i < d; i++) begin
            r = $urandom;
            for (int j = 0; j < w; j++) begin
                s[i*w+j] = r[j];
                acc[j]   = acc[j] ^ r[j];
            end
        end
        for (int j = 0; j < w; j++) s[j] = acc[j];
        return s;
    endfunction

    function automatic logic [7:0] unmask(input logic [23:0] s, input int w, input int d);
        logic [7:0] v;
        v = '0;
        for (int i = 0; i < d; i++)
            for (int j = 0; j < w; j++)
                v[j] = v[j] ^ s[i*w+j];
        return v;
    endfunction

    function automatic logic [7:0] refOp(input logic [1:0] md, input logic [7:0] a,
                                         input logic [7:0] b, input int w);
        logic [7:0] r;
        logic [7:0] m;
        m = 8'((32'd1 << w) - 1);
        case (md)
            2'b00:   r = a & b;
            2'b01:   r = ~(a & b);
            2'b10:   r = ~(a | b);
            default: r = a | b;
        endcase
        return r & m;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    task automatic applyStimulusA(input logic v, input logic [1:0] md, input logic [7:0] a,
                                  input logic [7:0] b, input logic [7:0] r);
        exp_t e;
        rstA_n   = 1'b1;
        inValidA = v;
        modeA    = md;
        inaA     = a;
        inbA     = b;
        rndA     = r;
        if (v) begin
            e.exp = refOp(md, unmask(24'(a), 4, 2), unmask(24'(b), 4, 2), 4);
            e.due = cyc + 2;
            qA.push_back(e);
        end
    endtask

    task automatic randA(input logic v, input logic [1:0] md, input logic [7:0] av, input logic [7:0] bv);
        @(negedge clk);
        applyStimulusA(v, md, 8'(maskSplit(av, 4, 2)), 8'(maskSplit(bv, 4, 2)), 8'($urandom));
    endtask

    task automatic applyStimulusB(input logic v, input logic [1:0] md, input logic [7:0] av,
                                  input logic [7:0] bv);
        exp_t e;
        @(negedge clk);
        rstB_n   = 1'b1;
        inValidB = v;
        modeB    = md;
        inaB     = maskSplit(av, 8, 3);
        inbB     = maskSplit(bv, 8, 3);
        rndB     = {16'($urandom), 32'($urandom)};
        if (v) begin
            e.exp = refOp(md, unmask(inaB, 8, 3), unmask(inbB, 8, 3), 8);
            e.due = cyc + 3;
            qB.push_back(e);
        end
    endtask

    // A synchronous reset discards everything that has not emerged by the reset edge.
    task automatic resetMidA();
        exp_t keep[$];
        @(negedge clk);
        rstA_n   = 1'b0;
        inValidA = 1'b1;
        modeA    = 2'($urandom);
        inaA     = 8'($urandom);
        inbA     = 8'($urandom);
        rndA     = 8'($urandom);
        foreach (qA[k]) if (qA[k].due <= cyc) keep.push_back(qA[k]);
        qA = keep;
    endtask

    always @(negedge clk) begin
        if (monOnA) begin
            if (qA.size() > 0 && qA[0].due == cyc) begin
                checkOutput("validA", 32'(outValidA), 32'd1);
                checkOutput("resultA", 32'(unmask(24'(outtA), 4, 2)), 32'(qA[0].exp));
                void'(qA.pop_front());
            end else begin
                checkOutput("bubbleValidA", 32'(outValidA), 32'd0);
            end
        end
    end

    always @(negedge clk) begin
        if (monOnB) begin
            if (qB.size() > 0 && qB[0].due == cyc) begin
                checkOutput("validB", 32'(outValidB), 32'd1);
                checkOutput("resultB", 32'(unmask(outtB, 8, 3)), 32'(qB[0].exp));
                void'(qB.pop_front());
            end else begin
                checkOutput("bubbleValidB", 32'(outValidB), 32'd0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rstA_n   = 1'b0;
        inValidA = 1'b1;
        modeA    = 2'($urandom);
        inaA     = 8'($urandom);
        inbA     = 8'($urandom);
        rndA     = 8'($urandom);
        rstB_n   = 1'b0;
        inValidB = 1'b0;
        modeB    = 2'b00;
        inaB     = '0;
        inbB     = '0;
        rndB     = '0;

        // Two reset edges with in_valid held high: nothing may emerge.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checkOutput("rstValidA", 32'(outValidA), 32'd0);
            checkOutput("rstOuttA", 32'(outtA), 32'd0);
            checkOutput("rstValidB", 32'(outValidB), 32'd0);
            checkOutput("rstOuttB", 32'(outtB), 32'd0);
            inaA = 8'($urandom);
            inbA = 8'($urandom);
        end
        monOnA = 1'b1;
        monOnB = 1'b1;
        rstB_n = 1'b1;

        // Mode sweep with a=1100, b=1010; the first one is issued right at release.
        applyStimulusA(1'b1, 2'd0, 8'(maskSplit(8'hC, 4, 2)), 8'(maskSplit(8'hA, 4, 2)), 8'($urandom));
        for (int md = 1; md < 4; md++) randA(1'b1, 2'(md), 8'hC, 8'hA);

        // Streaming with rotating modes and one bubble ahead of transaction 7.
        for (int k = 0; k < 16; k++) begin
            if (k == 7) randA(1'b0, 2'($urandom), 8'($urandom), 8'($urandom));
            randA(1'b1, 2'(k % 4), 8'($urandom), 8'($urandom));
        end

        // Zero randomness with fixed share splits.
        @(negedge clk);
        applyStimulusA(1'b1, 2'b00, 8'h0F, 8'h0F, 8'h00);
        @(negedge clk);
        applyStimulusA(1'b1, 2'b11, 8'h00, 8'h00, 8'h00);

        // Three transactions, reset one cycle later, then a fresh one after release.
        for (int k = 0; k < 3; k++) randA(1'b1, 2'($urandom), 8'($urandom), 8'($urandom));
        resetMidA();
        randA(1'b1, 2'($urandom), 8'($urandom), 8'($urandom));
        for (int k = 0; k < 4; k++) randA(1'b0, 2'b00, 8'h0, 8'h0);

        // Second instance has only seen zeros so far.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("idleOuttB", 32'(outtB), 32'd0);
        end

        for (int md = 0; md < 4; md++)
            for (int k = 0; k < 256; k++)
                applyStimulusB(1'b1, 2'(md), 8'(k), 8'($urandom));
        applyStimulusB(1'b0, 2'b00, 8'h0, 8'h0);

        repeat (6) @(negedge clk);
        checkOutput("drainedA", 32'(qA.size()), 32'd0);
        checkOutput("drainedB", 32'(qB.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
